// File: rtl/bft_out_arbiter.sv
// rtl/bft_out_arbiter.sv - round-robin arbiter sharing one BFT injection port among NUM_REQ requesters
// Optional BURST_LOCK_EN: last winner may hold the port for up to MAX_BURST consecutive grants.
module bft_out_arbiter #(
    parameter int PACKET_BITS   = 97,
    parameter int NUM_LEAF_BITS = 6,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_REQ       = 4,
    parameter int COUNT_BITS    = 16,
    parameter int MAX_BURST     = 4
) (
    input  logic                                                           clk,
    input  logic                                                           reset,
    input  logic [NUM_REQ-1:0]                                             req_valid,
    output logic [NUM_REQ-1:0]                                             req_ready,
    input  logic [NUM_REQ*NUM_LEAF_BITS-1:0]                               req_leaf,
    input  logic [NUM_REQ*NUM_PORT_BITS-1:0]                               req_port,
    input  logic [NUM_REQ*(PACKET_BITS-1-NUM_LEAF_BITS-NUM_PORT_BITS)-1:0] req_payload,
    output logic [PACKET_BITS-1:0]                                         o_bft_data,
    input  logic                                                           i_bft_ready,
    output logic [$clog2(NUM_REQ)-1:0]                                     o_grant_id,
    output logic [COUNT_BITS-1:0]                                          o_pkt_count
);
    localparam int PAYLOAD_BITS = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS;
    localparam int ID_BITS      = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || MAX_BURST < 1) begin : g_bad_params
        $error("bft_out_arbiter: NUM_REQ must be >= 2 and MAX_BURST >= 1");
    end

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t                   state_q, state_d;
    logic [PACKET_BITS-1:0]   data_q, data_d;
    logic [ID_BITS-1:0]       grant_q, grant_d;
    logic [ID_BITS-1:0]       ptr_q, ptr_d;
    logic [COUNT_BITS-1:0]    cnt_q, cnt_d;
    logic [ID_BITS-1:0]       win;
    logic                     found;
    logic                     xfer;
    logic                     free;
    logic                     lock;

    logic [NUM_LEAF_BITS-1:0] leaf_a [NUM_REQ];
    logic [NUM_PORT_BITS-1:0] port_a [NUM_REQ];
    logic [PAYLOAD_BITS-1:0]  pay_a  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign leaf_a[i] = req_leaf[i*NUM_LEAF_BITS +: NUM_LEAF_BITS];
        assign port_a[i] = req_port[i*NUM_PORT_BITS +: NUM_PORT_BITS];
        assign pay_a[i]  = req_payload[i*PAYLOAD_BITS +: PAYLOAD_BITS];
    end

`ifdef BURST_LOCK_EN
    localparam int BURST_BITS = $clog2(MAX_BURST + 1);
    logic [BURST_BITS-1:0] burst_q, burst_d;

    // A zero burst count means no grant has happened yet, so there is no winner to extend.
    assign lock = (burst_q != '0) && (burst_q < BURST_BITS'(MAX_BURST)) && req_valid[grant_q];
`else
    assign lock = 1'b0;
`endif

    always_comb begin
        int unsigned idx;
        idx   = 0;
        xfer  = (state_q == S_FULL) && i_bft_ready;
        free  = (state_q == S_EMPTY) || xfer;
        found = 1'b0;
        win   = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[ID_BITS'(idx)]) begin
                found = 1'b1;
                win   = ID_BITS'(idx);
            end
        end
        if (lock) begin
            found = 1'b1;
            win   = grant_q;
        end
        req_ready = '0;
        if (free && found) begin
            req_ready[win] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = xfer ? cnt_q + COUNT_BITS'(1) : cnt_q;
`ifdef BURST_LOCK_EN
        burst_d = burst_q;
`endif
        if (free) begin
            if (found) begin
                state_d = S_FULL;
                data_d  = {1'b1, leaf_a[win], port_a[win], pay_a[win]};
                grant_d = win;
                if (!lock) begin
                    ptr_d = (win == ID_BITS'(NUM_REQ - 1)) ? '0 : win + ID_BITS'(1);
                end
`ifdef BURST_LOCK_EN
                burst_d = lock ? burst_q + BURST_BITS'(1) : BURST_BITS'(1);
`endif
            end else begin
                state_d = S_EMPTY;
                data_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
`ifdef BURST_LOCK_EN
            burst_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
`ifdef BURST_LOCK_EN
            burst_q <= burst_d;
`endif
        end
    end

    assign o_bft_data  = data_q;
    assign o_grant_id  = grant_q;
    assign o_pkt_count = cnt_q;

endmodule

// File: tb/tb_bft_out_arbiter.sv
// tb/tb_bft_out_arbiter.sv - self-checking bench for bft_out_arbiter (default build, BURST_LOCK_EN undefined)
module tb_bft_out_arbiter;
    localparam int NR  = 4;
    localparam int LB  = 6;
    localparam int PB  = 4;
    localparam int PKB = 97;
    localparam int PLB = 86;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*LB-1:0]  req_leaf;
    logic [NR*PB-1:0]  req_port;
    logic [NR*PLB-1:0] req_payload;
    logic [PKB-1:0]    o_bft_data;
    logic              bft_ready;
    logic [1:0]        o_grant_id;
    logic [15:0]       o_pkt_count;

    logic [NR-1:0]     s_ready;
    logic [PKB-1:0]    s_data;
    logic [1:0]        s_grant;
    logic [3:0]        s_count;

    bft_out_arbiter u_dut (
        .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_leaf(req_leaf), .req_port(req_port), .req_payload(req_payload),
        .o_bft_data(o_bft_data), .i_bft_ready(bft_ready),
        .o_grant_id(o_grant_id), .o_pkt_count(o_pkt_count)
    );

    bft_out_arbiter #(.COUNT_BITS(4)) u_small (
        .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(s_ready),
        .req_leaf(req_leaf), .req_port(req_port), .req_payload(req_payload),
        .o_bft_data(s_data), .i_bft_ready(bft_ready),
        .o_grant_id(s_grant), .o_pkt_count(s_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit             m_full;
    logic [PKB-1:0] m_data;
    int             m_gid;
    int             m_ptr;
    int             m_cnt;
    logic [NR-1:0]  last_ready;

    typedef struct {
        bit            rst_before;
        logic [NR-1:0] v;
        logic          r;
        logic [NR-1:0] exp_ready;
        int            exp_gid;
        logic          exp_valid;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int first_valid(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [PKB-1:0] pkt_of(input int i);
        return {1'b1, req_leaf[i*LB +: LB], req_port[i*PB +: PB], req_payload[i*PLB +: PLB]};
    endfunction

    task automatic set_fields(input int i, input logic [LB-1:0] lf, input logic [PB-1:0] pt,
                              input logic [PLB-1:0] pl);
        req_leaf[i*LB +: LB]     = lf;
        req_port[i*PB +: PB]     = pt;
        req_payload[i*PLB +: PLB] = pl;
    endtask

    task automatic model_reset();
        m_full = 0;
        m_data = '0;
        m_gid  = 0;
        m_ptr  = 0;
        m_cnt  = 0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        bft_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cycle(input logic [NR-1:0] v, input logic r);
        int  w;
        bit  free;
        logic [NR-1:0] er;
        req_valid = v;
        bft_ready = r;
        #1;
        w    = first_valid(v, m_ptr);
        free = !m_full || r;
        er   = (free && w >= 0) ? NR'(1 << w) : '0;
        last_ready = req_ready;
        chk("req_ready", 128'(req_ready), 128'(er));
        if (m_full && r) m_cnt = (m_cnt + 1) % 65536;
        if (free) begin
            if (w >= 0) begin
                m_full = 1;
                m_data = pkt_of(w);
                m_gid  = w;
                m_ptr  = (w + 1) % NR;
            end else begin
                m_full = 0;
                m_data = '0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("o_bft_data", 128'(o_bft_data), 128'(m_data));
        chk("o_grant_id", 128'(o_grant_id), 128'(m_gid));
        chk("o_pkt_count", 128'(o_pkt_count), 128'(m_cnt));
        chk("small_pkt_count", 128'(s_count), 128'(m_cnt % 16));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PKB-1:0] held;
        logic [PKB-1:0] exp_pkt;

        rst_n = 1'b0;
        req_valid = '0;
        bft_ready = 1'b0;
        req_leaf = '0;
        req_port = '0;
        req_payload = '0;
        last_ready = '0;
        for (int i = 0; i < NR; i++) set_fields(i, LB'(i + 8), PB'(i + 9), PLB'(32'hA000 + i));
        @(negedge clk);
        #2;
        chk("reset_data", 128'(o_bft_data), 128'(0));
        chk("reset_ready", 128'(req_ready), 128'(0));
        chk("reset_grant", 128'(o_grant_id), 128'(0));
        chk("reset_count", 128'(o_pkt_count), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // single packet through a reserved-range port value
        set_fields(0, 6'd5, 4'd3, 86'h1234);
        cycle(4'b0001, 1'b1);
        exp_pkt = {1'b1, 6'd5, 4'd3, 86'h1234};
        chk("single_ready", 128'(last_ready), 128'(4'b0001));
        chk("single_data", 128'(o_bft_data), 128'(exp_pkt));
        cycle(4'b0000, 1'b1);
        chk("single_drain", 128'(o_bft_data), 128'(0));
        chk("single_count", 128'(o_pkt_count), 128'(1));

        // fairness (all valid) then two-requester alternation
        vecs.push_back('{1, 4'b1111, 1, 4'b0001, 0, 1});
        vecs.push_back('{0, 4'b1111, 1, 4'b0010, 1, 1});
        vecs.push_back('{0, 4'b1111, 1, 4'b0100, 2, 1});
        vecs.push_back('{0, 4'b1111, 1, 4'b1000, 3, 1});
        vecs.push_back('{0, 4'b1111, 1, 4'b0001, 0, 1});
        vecs.push_back('{0, 4'b1111, 1, 4'b0010, 1, 1});
        vecs.push_back('{0, 4'b0000, 1, 4'b0000, 1, 0});
        vecs.push_back('{1, 4'b0011, 1, 4'b0001, 0, 1});
        vecs.push_back('{0, 4'b0011, 1, 4'b0010, 1, 1});
        vecs.push_back('{0, 4'b0011, 1, 4'b0001, 0, 1});
        vecs.push_back('{0, 4'b0011, 1, 4'b0010, 1, 1});
        foreach (vecs[n]) begin
            if (vecs[n].rst_before) do_reset();
            cycle(vecs[n].v, vecs[n].r);
            chk($sformatf("vec%0d_ready", n), 128'(last_ready), 128'(vecs[n].exp_ready));
            chk($sformatf("vec%0d_gid", n), 128'(o_grant_id), 128'(vecs[n].exp_gid));
            chk($sformatf("vec%0d_valid", n), 128'(o_bft_data[PKB-1]), 128'(vecs[n].exp_valid));
            if (n == 6) chk("fair_count", 128'(o_pkt_count), 128'(6));
        end

        // backpressure holding req1's packet
        do_reset();
        cycle(4'b0010, 1'b1);
        held = o_bft_data;
        for (int i = 0; i < 5; i++) begin
            cycle(4'b0100, 1'b0);
            chk("bp_hold_data", 128'(o_bft_data), 128'(held));
            chk("bp_hold_ready", 128'(last_ready), 128'(0));
        end
        cycle(4'b0100, 1'b1);
        chk("bp_release_ready", 128'(last_ready), 128'(4'b0100));
        chk("bp_release_gid", 128'(o_grant_id), 128'(2));
        chk("bp_release_count", 128'(o_pkt_count), 128'(1));

        // asynchronous reset while FULL
        cycle(4'b0000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_data", 128'(o_bft_data), 128'(0));
        chk("async_count", 128'(o_pkt_count), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(4'b1100, 1'b1);
        chk("post_reset_ready", 128'(last_ready), 128'(4'b0100));

        // counter wrap on the 4-bit instance: 18 cycles give 17 transfers
        do_reset();
        for (int i = 0; i < 18; i++) cycle(4'b0001, 1'b1);
        chk("wrap_small", 128'(s_count), 128'(1));
        chk("wrap_big", 128'(o_pkt_count), 128'(17));

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NR; i++)
                set_fields(i, LB'($urandom), PB'($urandom),
                           {22'($urandom), 32'($urandom), 32'($urandom)});
            cycle(NR'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
